pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 175 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- two-entry (main + skid) valid/ready pipeline register.
//
// Provides full throughput with a fully registered in_ready: while the
// downstream stalls, one extra payload is absorbed into the skid entry, so
// upstream only sees back-pressure one cycle later. Latency is one cycle,
// and out_data always comes from the main register.
//
// Optional feature: define STAGE_PERF_CNT_EN to build a saturating
// back-pressure counter on stall_cnt. Without it, stall_cnt is tied to 0.
//
// Reset (rst) is synchronous and active-low, and it overrides flush and
// all handshakes.

module pipe_stage_reg #(
    parameter int DATA_W      = 32,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [DATA_W-1:0]  main_reg;
    logic [DATA_W-1:0]  skid_reg;

    logic               in_fire;
    logic               out_fire;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid_in;

    // Handshake qualifiers use the registered flags, so neither in_ready
    // nor out_valid ever depends combinationally on an input.
    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = out_valid_reg & out_ready;

    // Next-state decode and payload-load strobes; flush overrides every transition.
    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;

        case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_next   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    // Streaming case: the main entry is replaced in place.
                    load_main_in = 1'b1;
                    state_next   = ST_ONE;
                end else if (in_fire) begin
                    // Downstream stalled: park the new payload in skid.
                    load_skid_in = 1'b1;
                    state_next   = ST_TWO;
                end else if (out_fire) begin
                    state_next   = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_next     = ST_ONE;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase

        if (flush) begin
            state_next     = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    // FSM register plus the registered handshake flags derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next != ST_TWO);
            out_valid_reg <= (state_next != ST_EMPTY);
        end
    end

    // Main payload register: loads from the input or from skid, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_reg <= '0;
        end else if (flush) begin
            if (ZERO_BUBBLE != 0) begin
                main_reg <= '0;
            end
        end else if (load_main_in) begin
            main_reg <= in_data;
        end else if (load_main_skid) begin
            main_reg <= skid_reg;
        end
    end

    // Skid payload register: captures only when the downstream stalls in ONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            skid_reg <= '0;
        end else if (flush) begin
            if (ZERO_BUBBLE != 0) begin
                skid_reg <= '0;
            end
        end else if (load_skid_in) begin
            skid_reg <= in_data;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;

    // When bubbles are zeroed, each output bit is gated by out_valid. This
    // hides stale main contents after a drain without an extra register write.
    generate
        if (ZERO_BUBBLE != 0) begin : g_zero_bubble
            for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
                assign out_data[gi] = main_reg[gi] & out_valid_reg;
            end
        end else begin : g_raw_out
            assign out_data = main_reg;
        end
    endgenerate

`ifdef STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Count cycles where data waits on the downstream. The count saturates,
    // only reset clears it, and flush does not touch it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_reg <= 32'd0;
        end else if (out_valid_reg && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg.
// Two instances share one clock and reset:
//   - a 32-bit instance for the directed scenarios;
//   - a 7-bit instance for random traffic.
// For each instance, a negedge monitor keeps a scoreboard queue. Accepted
// payloads are pushed, and every downstream transfer pops and compares.

module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;

    logic        c_flush;
    logic        c_in_valid;
    logic        c_in_ready;
    logic [31:0] c_in_data;
    logic        c_out_valid;
    logic        c_out_ready;
    logic [31:0] c_out_data;
    logic [31:0] c_stall_cnt;

    logic        r_flush;
    logic        r_in_valid;
    logic        r_in_ready;
    logic [6:0]  r_in_data;
    logic        r_out_valid;
    logic        r_out_ready;
    logic [6:0]  r_out_data;
    logic [31:0] r_stall_cnt;

    logic [31:0] q32[$];
    logic [6:0]  q7[$];

    int checks = 0;
    int passes = 0;

    pipe_stage_reg #(.DATA_W(32), .ZERO_BUBBLE(1)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .flush     (c_flush),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_data   (c_in_data),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_data  (c_out_data),
        .stall_cnt (c_stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(7), .ZERO_BUBBLE(1)) dut7 (
        .clk       (clk),
        .rst       (rst),
        .flush     (r_flush),
        .in_valid  (r_in_valid),
        .in_ready  (r_in_ready),
        .in_data   (r_in_data),
        .out_valid (r_out_valid),
        .out_ready (r_out_ready),
        .out_data  (r_out_data),
        .stall_cnt (r_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitors. Inputs change only at posedge+1, so the values
    // sampled at negedge are exactly what the next rising edge will use.
    always @(negedge clk) begin
        if (rst) begin
            if (c_out_valid && c_out_ready) begin
                checks++;
                if (q32.size() == 0) begin
                    $display("FAIL sb32_spurious: out_data=%h emitted, nothing expected", c_out_data);
                end else if (c_out_data !== q32[0]) begin
                    $display("FAIL sb32_order: out_data=%h expected=%h", c_out_data, q32[0]);
                    void'(q32.pop_front());
                end else begin
                    passes++;
                    $display("sb32 out %h", c_out_data);
                    void'(q32.pop_front());
                end
            end
            if (c_flush) q32.delete();
            else if (c_in_valid && c_in_ready) q32.push_back(c_in_data);
        end else begin
            q32.delete();
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (r_out_valid && r_out_ready) begin
                checks++;
                if (q7.size() == 0) begin
                    $display("FAIL sb7_spurious: out_data=%h emitted, nothing expected", r_out_data);
                end else if (r_out_data !== q7[0]) begin
                    $display("FAIL sb7_order: out_data=%h expected=%h", r_out_data, q7[0]);
                    void'(q7.pop_front());
                end else begin
                    passes++;
                    void'(q7.pop_front());
                end
            end
            if (r_flush) q7.delete();
            else if (r_in_valid && r_in_ready) q7.push_back(r_in_data);
        end else begin
            q7.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        c_in_valid = 1'b1; c_in_data = 32'hDEADBEEF; c_out_ready = 1'b0; c_flush = 1'b0;
        tick(); tick();
        checks++; if (c_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", c_out_valid); else passes++;
        checks++; if (c_out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", c_out_data); else passes++;
        checks++; if (c_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", c_in_ready); else passes++;
        checks++; if (c_stall_cnt !== 32'h0) $display("FAIL reset_stall_cnt: got %h want 0", c_stall_cnt); else passes++;
        checks++; if (r_out_valid !== 1'b0) $display("FAIL reset7_out_valid: got %b want 0", r_out_valid); else passes++;
        $display("test_reset done");
        c_in_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] vals[3];
        vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
        c_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_in_valid = 1'b1; c_in_data = vals[i];
            checks++; if (c_in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, c_in_ready); else passes++;
            tick();
            checks++;
            if (c_out_valid !== 1'b1 || c_out_data !== vals[i])
                $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, c_out_valid, c_out_data, vals[i]);
            else passes++;
        end
        c_in_valid = 1'b0;
        tick();
        checks++;
        if (c_out_valid !== 1'b0 || c_out_data !== 32'h0)
            $display("FAIL stream_drain: got v=%b d=%h want v=0 d=0", c_out_valid, c_out_data);
        else passes++;
    endtask

    task automatic test_skid();
        c_out_ready = 1'b0;
        c_in_valid = 1'b1; c_in_data = 32'hA;
        tick();
        c_in_data = 32'hB;
        tick();
        checks++;
        if (c_in_ready !== 1'b0 || c_out_valid !== 1'b1 || c_out_data !== 32'hA)
            $display("FAIL skid_two: got rdy=%b v=%b d=%h want rdy=0 v=1 d=a", c_in_ready, c_out_valid, c_out_data);
        else passes++;
        // Input changes while in_ready=0 must not be captured.
        c_in_data = 32'h55;
        tick();
        checks++;
        if (c_in_ready !== 1'b0 || c_out_data !== 32'hA)
            $display("FAIL skid_hold: got rdy=%b d=%h want rdy=0 d=a", c_in_ready, c_out_data);
        else passes++;
        c_in_valid = 1'b0; c_out_ready = 1'b1;
        tick();
        checks++;
        if (c_in_ready !== 1'b1 || c_out_valid !== 1'b1 || c_out_data !== 32'hB)
            $display("FAIL skid_drain1: got rdy=%b v=%b d=%h want rdy=1 v=1 d=b", c_in_ready, c_out_valid, c_out_data);
        else passes++;
        tick();
        checks++;
        if (c_out_valid !== 1'b0 || q32.size() != 0)
            $display("FAIL skid_empty: got v=%b pending=%0d want v=0 pending=0", c_out_valid, q32.size());
        else passes++;
    endtask

    task automatic test_flush();
        c_out_ready = 1'b0;
        c_in_valid = 1'b1; c_in_data = 32'h11;
        tick();
        c_in_data = 32'h22;
        tick();
        c_flush = 1'b1; c_in_data = 32'hC;
        tick();
        checks++;
        if (c_out_valid !== 1'b0 || c_out_data !== 32'h0 || c_in_ready !== 1'b1)
            $display("FAIL flush_empty: got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", c_out_valid, c_out_data, c_in_ready);
        else passes++;
        c_flush = 1'b0; c_in_valid = 1'b0;
        tick();
        checks++;
        if (c_out_valid !== 1'b0 || q32.size() != 0)
            $display("FAIL flush_no_capture: got v=%b pending=%0d want v=0 pending=0", c_out_valid, q32.size());
        else passes++;
    endtask

    task automatic test_reset_mid();
        c_out_ready = 1'b0;
        c_in_valid = 1'b1; c_in_data = 32'h77;
        tick();
        c_in_data = 32'h88;
        rst = 1'b0;
        tick();
        rst = 1'b1; c_in_valid = 1'b0;
        checks++;
        if (c_out_valid !== 1'b0 || c_out_data !== 32'h0 || c_in_ready !== 1'b1)
            $display("FAIL reset_mid: got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", c_out_valid, c_out_data, c_in_ready);
        else passes++;
        c_out_ready = 1'b1;
        tick();
        checks++;
        if (c_out_valid !== 1'b0)
            $display("FAIL reset_mid_after: got v=%b want 0", c_out_valid);
        else passes++;
    endtask

    task automatic test_counter();
        logic [31:0] exp_cnt;
`ifdef STAGE_PERF_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        c_out_ready = 1'b0;
        c_in_valid = 1'b1; c_in_data = 32'h99;
        tick();
        c_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (c_stall_cnt !== exp_cnt)
            $display("FAIL counter_stall: got %0d want %0d", c_stall_cnt, exp_cnt);
        else passes++;
        // A flush with the output accepted must leave the count untouched.
        c_flush = 1'b1; c_out_ready = 1'b1;
        tick();
        c_flush = 1'b0;
        checks++;
        if (c_stall_cnt !== exp_cnt || c_out_valid !== 1'b0)
            $display("FAIL counter_flush: got cnt=%0d v=%b want cnt=%0d v=0", c_stall_cnt, c_out_valid, exp_cnt);
        else passes++;
        $display("test_counter stall_cnt=%0d", c_stall_cnt);
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = checks - passes;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checks++;
            if (r_in_ready !== (q7.size() < 2)) begin
                $display("FAIL rand_in_ready cyc=%0d: got %b with %0d held", cyc, r_in_ready, q7.size());
            end else passes++;
            checks++;
            if (r_out_valid !== (q7.size() != 0)) begin
                $display("FAIL rand_out_valid cyc=%0d: got %b with %0d held", cyc, r_out_valid, q7.size());
            end else passes++;
            if (!r_out_valid) begin
                checks++;
                if (r_out_data !== 7'h0) $display("FAIL rand_bubble cyc=%0d: got %h want 0", cyc, r_out_data);
                else passes++;
            end
            r_in_valid  = 1'($urandom_range(0, 1));
            r_in_data   = 7'($urandom_range(0, 127));
            r_out_ready = 1'($urandom_range(0, 1));
            r_flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        r_in_valid = 1'b0; r_flush = 1'b0; r_out_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (r_out_valid !== 1'b0 || q7.size() != 0)
            $display("FAIL rand_drain: got v=%b pending=%0d want v=0 pending=0", r_out_valid, q7.size());
        else passes++;
        $display("test_random done, new failures=%0d", (checks - passes) - errs_before);
    endtask

    initial begin
        rst = 1'b0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = 32'h0; c_out_ready = 1'b0;
        r_flush = 1'b0; r_in_valid = 1'b0; r_in_data = 7'h0; r_out_ready = 1'b0;
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_reset_mid();
        test_counter();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
